// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable pulse/pulse-train generator with one-shot, retrigger and continuous modes.
// Optional feature macro: PULSE_TRAIN_IDX_EN adds the pulse_idx output (index of current/last pulse).
module pulse_train_gen #(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] len,
    input  logic [CNT_W-1:0] gap,
    input  logic [REP_W-1:0] reps,
    output logic             dout,
    output logic             busy,
`ifdef PULSE_TRAIN_IDX_EN
    output logic [REP_W-1:0] pulse_idx,
`endif
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] M_RETRIG = 2'd1;
    localparam logic [1:0] M_CONT   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [REP_W-1:0] REP_ONE = 1;

    logic [1:0]       r_state;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_gap;
    logic [REP_W-1:0] r_reps;
    logic [CNT_W-1:0] r_cnt;
    logic [REP_W-1:0] r_pcnt;
    logic             r_dout;
    logic             r_busy;
    logic             r_done;

    logic [CNT_W-1:0] w_len_last;
    logic [CNT_W-1:0] w_gap_last;
    logic [REP_W-1:0] w_reps_last;
    logic [REP_W-1:0] w_pcnt_inc;
    logic             w_high_end;
    logic             w_gap_end;
    logic             w_more;
    logic             w_start;
    logic [1:0]       w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [REP_W-1:0] w_nxt_pcnt;
    logic             w_nxt_done;

    // A zero length/gap/reps behaves like one, so the terminal count is value-1 clamped at 0.
    assign w_len_last  = (r_len  == '0) ? '0 : r_len  - CNT_ONE;
    assign w_gap_last  = (r_gap  == '0) ? '0 : r_gap  - CNT_ONE;
    assign w_reps_last = (r_reps == '0) ? '0 : r_reps - REP_ONE;
    assign w_pcnt_inc  = (r_pcnt == '1) ? r_pcnt : r_pcnt + REP_ONE;
    assign w_high_end  = (r_cnt == w_len_last);
    assign w_gap_end   = (r_cnt == w_gap_last);
    assign w_more      = (r_mode == M_CONT) || (r_pcnt < w_reps_last);
    // Only an idle block or a running retrigger-mode train accepts a start; abort always wins.
    assign w_start     = trig && !abort && ((r_state == S_IDLE) || (r_mode == M_RETRIG));

    // Next-state, counter and completion-strobe decision for the train sequencer.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_pcnt  = r_pcnt;
        w_nxt_done  = 1'b0;
        if (abort) begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_pcnt  = '0;
        end else if (w_start) begin
            w_nxt_state = S_HIGH;
            w_nxt_cnt   = '0;
            w_nxt_pcnt  = '0;
        end else if (r_state == S_HIGH) begin
            if (w_high_end) begin
                w_nxt_cnt   = '0;
                w_nxt_state = w_more ? S_GAP : S_IDLE;
                w_nxt_pcnt  = w_more ? w_pcnt_inc : r_pcnt;
                w_nxt_done  = !w_more;
            end else begin
                w_nxt_cnt = r_cnt + CNT_ONE;
            end
        end else if (r_state == S_GAP) begin
            w_nxt_state = w_gap_end ? S_HIGH : S_GAP;
            w_nxt_cnt   = w_gap_end ? '0 : r_cnt + CNT_ONE;
        end else if (r_state != S_IDLE) begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
        end
    end

    // Sequencer state, configuration latched at each start, and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= '0;
            r_len   <= '0;
            r_gap   <= '0;
            r_reps  <= '0;
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_dout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_pcnt  <= w_nxt_pcnt;
            r_dout  <= (w_nxt_state == S_HIGH);
            r_busy  <= (w_nxt_state != S_IDLE);
            r_done  <= w_nxt_done;
            if (w_start) begin
                r_mode <= mode;
                r_len  <= len;
                r_gap  <= gap;
                r_reps <= reps;
            end
        end
    end

`ifdef PULSE_TRAIN_IDX_EN
    logic [REP_W-1:0] r_idx;
    logic [REP_W-1:0] w_nxt_idx;

    // Index advances on each gap-to-high transition, saturating, and holds after the train ends.
    always_comb begin
        w_nxt_idx = r_idx;
        if (!abort && w_start)
            w_nxt_idx = '0;
        else if (!abort && (r_state == S_GAP) && w_gap_end)
            w_nxt_idx = (r_idx == '1) ? r_idx : r_idx + REP_ONE;
    end

    // Pulse index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_idx <= '0;
        else
            r_idx <= w_nxt_idx;
    end

    assign pulse_idx = r_idx;
`endif

    assign dout = r_dout;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: scoreboard bench for pulse_train_gen driven by directed per-cycle vectors.
module tb_pulse_train_gen;

    logic        clk;
    logic        rst_n;
    logic        trig;
    logic        abort;
    logic [1:0]  mode;
    logic [15:0] len;
    logic [15:0] gap;
    logic [7:0]  reps;
    logic        dout;
    logic        busy;
    logic        done;
`ifdef PULSE_TRAIN_IDX_EN
    logic [7:0]  pulse_idx;
`endif

    int          cyc;
    int          checks;
    int          failures;
    int          q_cyc[$];
    logic [2:0]  q_exp[$];
    string       q_nm[$];

    pulse_train_gen #(.CNT_W(16), .REP_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .trig(trig),
        .abort(abort),
        .mode(mode),
        .len(len),
        .gap(gap),
        .reps(reps),
        .dout(dout),
        .busy(busy),
`ifdef PULSE_TRAIN_IDX_EN
        .pulse_idx(pulse_idx),
`endif
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due this cycle and compare {dout,busy,done}.
    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            int    ec;
            logic [2:0] ee;
            string en;
            ec = q_cyc.pop_front();
            ee = q_exp.pop_front();
            en = q_nm.pop_front();
            checks++;
            if (ec != cyc || {dout, busy, done} !== ee) begin
                failures++;
                $display("FAIL %s cyc=%0d due=%0d got dout,busy,done=%b exp=%b", en, cyc, ec, {dout, busy, done}, ee);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [2:0] code(input byte c);
        return (c == "H") ? 3'b110 : (c == "G") ? 3'b010 : (c == "D") ? 3'b001 : 3'b000;
    endfunction

    task automatic step(input logic t, input logic a, input logic [2:0] e, input string nm, input bit rst_after);
        trig  = t;
        abort = a;
        q_cyc.push_back(cyc + 1);
        q_exp.push_back(e);
        q_nm.push_back(nm);
        @(posedge clk);
        #1;
        if (rst_after) rst_n = 1'b0;
    endtask

    // tr/ab: per-cycle trig/abort ('1' = high, missing = low); ex: H=high, G=gap, D=done, I=idle.
    task automatic run_seq(input string nm, input string tr, input string ab, input string ex, input bit scramble);
        for (int i = 0; i < ex.len(); i++) begin
            step(i < tr.len() && tr[i] == "1", i < ab.len() && ab[i] == "1", code(ex[i]),
                 $sformatf("%s[%0d]", nm, i), 1'b0);
            if (scramble && i == 0) begin
                mode = 2'd1;
                len  = 16'd7;
                gap  = 16'd7;
                reps = 8'd7;
            end
        end
        trig  = 1'b0;
        abort = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] m, input logic [15:0] l, input logic [15:0] g, input logic [7:0] r);
        mode = m;
        len  = l;
        gap  = g;
        reps = r;
    endtask

    initial begin
        cyc = 0; checks = 0; failures = 0;
        rst_n = 1'b0; trig = 1'b0; abort = 1'b0;
        cfg(2'd0, 16'd10, 16'd0, 8'd1);
        run_seq("reset", "1", "", "II", 1'b0);
        rst_n = 1'b1;
        run_seq("idle", "", "", "I", 1'b0);
        cfg(2'd0, 16'd10, 16'd0, 8'd1);
        run_seq("oneshot10", "1", "", "HHHHHHHHHHDI", 1'b0);
        cfg(2'd0, 16'd3, 16'd2, 8'd3);
        run_seq("train3x3", "100001", "", "HHHGGHHHGGHHHDI", 1'b1);
        cfg(2'd1, 16'd8, 16'd1, 8'd1);
        run_seq("retrig_high", "100001", "", "HHHHHHHHHHHHHDI", 1'b0);
        cfg(2'd1, 16'd2, 16'd3, 8'd2);
        run_seq("retrig_gap", "10001", "", "HHGGHHGGGHHDI", 1'b0);
        cfg(2'd2, 16'd2, 16'd1, 8'd1);
        run_seq("cont_abort", "10000000001", "0000000000000000000001", "HHGHHGHHGHHGHHGHHGHHGII", 1'b1);
        cfg(2'd0, 16'd0, 16'd0, 8'd0);
        run_seq("zero_cfg", "1", "", "HDI", 1'b0);
        run_seq("abort_trig_idle", "1", "1", "II", 1'b0);
        run_seq("trig_on_done", "101", "", "HDHDI", 1'b0);
        cfg(2'd0, 16'd0, 16'd0, 8'd2);
        run_seq("zero_len_gap_reps2", "1", "", "HGHDI", 1'b0);
        cfg(2'd3, 16'd2, 16'd1, 8'd1);
        run_seq("mode3_oneshot", "101", "", "HHDI", 1'b0);
        cfg(2'd0, 16'd10, 16'd0, 8'd1);
        run_seq("pre_rst", "1", "", "HHH", 1'b0);
        step(1'b0, 1'b0, 3'b000, "rst_mid_high", 1'b1);
        step(1'b0, 1'b0, 3'b000, "rst_hold", 1'b0);
        rst_n = 1'b1;
        cfg(2'd0, 16'd2, 16'd0, 8'd1);
        run_seq("post_rst", "1", "", "HHDII", 1'b0);
        repeat (2) @(negedge clk);
        #1;
        if (q_cyc.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q_cyc.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
